// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and word type for the register file
package regfile_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  localparam int ZERO_IDX = 0;
  typedef logic [DEFAULT_WIDTH-1:0] word_t;
endpackage

// File: rtl/regfile_entry.sv
// regfile_entry: one register-file word with async reset, sync clear and write enable
module regfile_entry #(
  parameter int WIDTH = regfile_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (clear) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/param_regfile.sv
// param_regfile: DEPTH x WIDTH register file, two combinational reads, one write,
// optional hardwired zero entry, optional write-to-read bypass, sync bulk clear.
module param_regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter bit ZERO_REG = 1,
  parameter bit BYPASS = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd1_num,
  output logic [WIDTH-1:0]  rd1_data,
  input  logic [ADDR_W-1:0] rd2_num,
  output logic [WIDTH-1:0]  rd2_data
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_ok, rd1_ok, rd2_ok, byp1, byp2;
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gen_e
      if (ZERO_REG && g == ZERO_IDX) begin : gen_zero
        assign mem[g] = '0;
      end else begin : gen_reg
        regfile_entry #(.WIDTH(WIDTH)) u_e (
          .clk(clk),
          .reset(reset),
          .clear(clear),
          .en(wr_enable && wr_num == ADDR_W'(g)),
          .d(wr_data),
          .q(mem[g])
        );
      end
    end
  endgenerate
  // A write only forwards if it would actually land in a real, writable entry
  assign wr_ok = wr_enable && !clear && !reset && ({1'b0, wr_num} < LIM)
                 && !(ZERO_REG && wr_num == ADDR_W'(ZERO_IDX));
  assign rd1_ok = {1'b0, rd1_num} < LIM;
  assign rd2_ok = {1'b0, rd2_num} < LIM;
  assign byp1 = BYPASS && wr_ok && wr_num == rd1_num;
  assign byp2 = BYPASS && wr_ok && wr_num == rd2_num;
  assign rd1_data = reset ? '0 : byp1 ? wr_data : rd1_ok ? mem[rd1_num] : '0;
  assign rd2_data = reset ? '0 : byp2 ? wr_data : rd2_ok ? mem[rd2_num] : '0;
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: directed scoreboard bench over four register-file configurations
module tb_param_regfile;
  typedef struct {
    string       tag;
    int          inst;
    bit          port;
    logic [31:0] exp;
  } exp_t;

  logic clk = 0, reset = 1, clear = 0, we = 0;
  logic [4:0] wn = 0, r1 = 0, r2 = 0;
  logic [31:0] wd = 0;
  logic [31:0] o1 [4];
  logic [31:0] o2 [4];
  exp_t q[$];
  int ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  // 0: ZERO_REG=1 BYPASS=0, 1: ZERO_REG=0, 2: BYPASS=1, 3: DEPTH=20
  param_regfile #(.ZERO_REG(1), .BYPASS(0)) u0 (.clk(clk), .reset(reset), .clear(clear),
    .wr_enable(we), .wr_num(wn), .wr_data(wd), .rd1_num(r1), .rd1_data(o1[0]), .rd2_num(r2), .rd2_data(o2[0]));
  param_regfile #(.ZERO_REG(0), .BYPASS(0)) u1 (.clk(clk), .reset(reset), .clear(clear),
    .wr_enable(we), .wr_num(wn), .wr_data(wd), .rd1_num(r1), .rd1_data(o1[1]), .rd2_num(r2), .rd2_data(o2[1]));
  param_regfile #(.ZERO_REG(1), .BYPASS(1)) u2 (.clk(clk), .reset(reset), .clear(clear),
    .wr_enable(we), .wr_num(wn), .wr_data(wd), .rd1_num(r1), .rd1_data(o1[2]), .rd2_num(r2), .rd2_data(o2[2]));
  param_regfile #(.DEPTH(20)) u3 (.clk(clk), .reset(reset), .clear(clear),
    .wr_enable(we), .wr_num(wn), .wr_data(wd), .rd1_num(r1), .rd1_data(o1[3]), .rd2_num(r2), .rd2_data(o2[3]));

  task automatic expect_v(input string tag, input int inst, input bit port, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.inst = inst; e.port = port; e.exp = v;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      obs = e.port ? o2[e.inst] : o1[e.inst];
      ncmp++;
      assert (obs === e.exp) else begin
        nerr++;
        $error("FAIL %s (inst %0d port %0d): observed %h expected %h", e.tag, e.inst, e.port + 1, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    r1 = 5; r2 = 31;
    for (int i = 0; i < 4; i++) begin
      expect_v("reset_rd1", i, 0, 0);
      expect_v("reset_rd2", i, 1, 0);
    end
    check();
    // write latency vs bypass
    we = 1; wn = 7; wd = 32'hDEADBEEF; r1 = 7; r2 = 7;
    expect_v("lat_old", 0, 0, 0);
    expect_v("byp_same", 2, 0, 32'hDEADBEEF);
    check();
    tick();
    we = 0;
    expect_v("lat_new1", 0, 0, 32'hDEADBEEF);
    expect_v("lat_new2", 0, 1, 32'hDEADBEEF);
    expect_v("lat_new_d20", 3, 1, 32'hDEADBEEF);
    check();
    // zero register
    we = 1; wn = 0; wd = 32'h12345678; r1 = 0; r2 = 0;
    expect_v("zero_nobyp", 2, 1, 0);
    expect_v("nz_before", 1, 0, 0);
    check();
    tick();
    we = 0;
    expect_v("zero_rd", 0, 0, 0);
    expect_v("nz_rd", 1, 0, 32'h12345678);
    check();
    // bypass and clear suppressing it
    we = 1; wn = 3; wd = 32'hA5A5A5A5; r2 = 3;
    expect_v("byp_hit", 2, 1, 32'hA5A5A5A5);
    expect_v("nobyp", 0, 1, 0);
    check();
    clear = 1;
    expect_v("byp_clear", 2, 1, 0);
    check();
    tick();
    clear = 0; we = 0; r1 = 7;
    expect_v("clr_e3", 2, 1, 0);
    expect_v("clr_e3_b0", 0, 1, 0);
    expect_v("clr_e7", 0, 0, 0);
    check();
    // clear beats write
    for (int i = 1; i <= 4; i++) begin
      we = 1; wn = 5'(i); wd = i;
      tick();
    end
    we = 0; r1 = 2; r2 = 4;
    expect_v("fill2", 0, 0, 2);
    expect_v("fill4", 0, 1, 4);
    check();
    clear = 1; we = 1; wn = 2; wd = 32'hFF;
    tick();
    clear = 0; we = 0;
    for (int i = 1; i <= 4; i++) begin
      r1 = 5'(i);
      expect_v("clr_pri", 0, 0, 0);
      expect_v("clr_pri_z0", 1, 0, 0);
      check();
    end
    // DEPTH=20: top entry, async reset, out-of-range
    we = 1; wn = 19; wd = 32'h55;
    tick();
    we = 0; r1 = 19;
    expect_v("d20_e19", 3, 0, 32'h55);
    check();
    #1;
    we = 1; wn = 3; wd = 32'h1; r2 = 3; reset = 1;
    expect_v("async_rst", 3, 0, 0);
    expect_v("rst_nobyp", 2, 1, 0);
    check();
    reset = 0; we = 0;
    expect_v("after_rst", 3, 0, 0);
    expect_v("after_rst_d32", 0, 0, 0);
    check();
    we = 1; wn = 25; wd = 32'h77;
    tick();
    we = 0; r1 = 25; r2 = 9;
    expect_v("oor_rd", 3, 0, 0);
    expect_v("oor_alias9", 3, 1, 0);
    expect_v("d32_e25", 0, 0, 32'h77);
    check();
    r2 = 5;
    expect_v("oor_alias5", 3, 1, 0);
    check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
